// File: rtl/bcd_display_mux.sv
// Three-digit time-multiplexed seven-segment driver with frame-aligned update.
// Optional leading-zero blanking is enabled by BCD_LEADING_ZERO_BLANK_EN.
module bcd_display_mux #(
    parameter int REFRESH_DIV = 50000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] cen,
    input  logic [3:0] dez,
    input  logic [3:0] und,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       frame_tick,
    output logic       pending
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [11:0]   shadow_q, shadow_d;
    logic [11:0]   disp_q, disp_d;
    logic          pend_q, pend_d;
    logic          tick_q, tick_d;
    logic [6:0]    seg_q, seg_d;
    logic [2:0]    an_q, an_d;

    logic          wrap;
    logic          boundary;
    logic [3:0]    sel_nib;
    logic          blank_cen;
    logic          blank_dez;
    logic          sel_blank;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    assign wrap     = (cnt_q == CNT_MAX);
    assign boundary = wrap && (idx_q == 2'd2);

`ifdef BCD_LEADING_ZERO_BLANK_EN
    assign blank_cen = (disp_q[11:8] == 4'd0);
    assign blank_dez = blank_cen && (disp_q[7:4] == 4'd0);
`else
    assign blank_cen = 1'b0;
    assign blank_dez = 1'b0;
`endif

    // Scan counter, shadow/display hand-off and output encoding
    always_comb begin
        cnt_d     = wrap ? '0 : cnt_q + CW'(1);
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        disp_d    = disp_q;
        pend_d    = pend_q;
        tick_d    = 1'b0;
        sel_nib   = disp_q[3:0];
        sel_blank = 1'b0;

        if (wrap) begin
            idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end

        if (load) begin
            shadow_d = {cen, dez, und};
            pend_d   = 1'b1;
        end

        if (boundary) begin
            if (load) begin
                disp_d = {cen, dez, und};
                pend_d = 1'b0;
                tick_d = 1'b1;
            end else if (pend_q) begin
                disp_d = shadow_q;
                pend_d = 1'b0;
                tick_d = 1'b1;
            end
        end

        case (idx_q)
            2'd1: begin
                sel_nib   = disp_q[7:4];
                sel_blank = blank_dez;
            end
            2'd2: begin
                sel_nib   = disp_q[11:8];
                sel_blank = blank_cen;
            end
            default: begin
                sel_nib   = disp_q[3:0];
                sel_blank = 1'b0;
            end
        endcase

        seg_d = sel_blank ? 7'h00 : decode(sel_nib);
        an_d  = 3'(3'b001 << idx_q);
    end

    // State and registered outputs, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            idx_q    <= 2'd0;
            shadow_q <= 12'd0;
            disp_q   <= 12'd0;
            pend_q   <= 1'b0;
            tick_q   <= 1'b0;
            seg_q    <= 7'h00;
            an_q     <= 3'b000;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            disp_q   <= disp_d;
            pend_q   <= pend_d;
            tick_q   <= tick_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
        end
    end

    assign seg        = seg_q ^ {7{ACTIVE_LOW}};
    assign an         = an_q ^ {3{ACTIVE_LOW}};
    assign frame_tick = tick_q;
    assign pending    = pend_q;

endmodule

// File: tb/tb_bcd_display_mux.sv
// Directed self-checking bench for bcd_display_mux (REFRESH_DIV=4, active-low).
// Expectations follow BCD_LEADING_ZERO_BLANK_EN when it is defined.
module tb_bcd_display_mux;

    localparam int RD = 4;
    localparam logic [6:0] SINV = 7'h7F;
    localparam logic [2:0] AINV = 3'b111;

`ifdef BCD_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] ZL = 7'h00;
`else
    localparam logic [6:0] ZL = 7'h3F;
`endif

    logic       clk;
    logic       rst_n;
    logic       load;
    logic [3:0] cen;
    logic [3:0] dez;
    logic [3:0] und;
    logic [6:0] seg;
    logic [2:0] an;
    logic       frame_tick;
    logic       pending;

    int checks;
    int failures;
    int cyc;

    bcd_display_mux #(
        .REFRESH_DIV(RD),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .cen       (cen),
        .dez       (dez),
        .und       (und),
        .seg       (seg),
        .an        (an),
        .frame_tick(frame_tick),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc = cyc + 1;
    endtask

    task automatic run_to(input int k);
        while (cyc < k) step();
    endtask

    task automatic test_reset();
        logic [6:0] es;
        logic [2:0] ea;
        rst_n = 1'b0;
        load  = 1'b0;
        cen   = 4'd0;
        dez   = 4'd0;
        und   = 4'd0;
        cyc   = 0;
        #1;
        checks++;
        if (seg !== SINV) begin
            failures++;
            $display("FAIL rst_seg: got %h want %h", seg, SINV);
        end
        checks++;
        if (an !== AINV) begin
            failures++;
            $display("FAIL rst_an: got %b want %b", an, AINV);
        end
        checks++;
        if (frame_tick !== 1'b0 || pending !== 1'b0) begin
            failures++;
            $display("FAIL rst_flags: tick %b pend %b want 0 0",
                     frame_tick, pending);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            ea = 3'(3'b001 << ((k - 1) / RD)) ^ AINV;
            es = (((k - 1) / RD) == 0 ? 7'h3F : ZL) ^ SINV;
            checks++;
            if (an !== ea) begin
                failures++;
                $display("FAIL hold_an c%0d: got %b want %b", k, an, ea);
            end
            checks++;
            if (seg !== es) begin
                failures++;
                $display("FAIL hold_seg c%0d: got %h want %h", k, seg, es);
            end
            checks++;
            if (frame_tick !== 1'b0) begin
                failures++;
                $display("FAIL hold_tick c%0d: got %b want 0", k, frame_tick);
            end
        end
    endtask

    task automatic test_load_mid();
        logic [6:0] e [3];
        e[0] = 7'h66;
        e[1] = 7'h66;
        e[2] = 7'h06;
        run_to(12);
        load = 1'b1;
        cen  = 4'd1;
        dez  = 4'd4;
        und  = 4'd4;
        step();
        load = 1'b0;
        while (cyc < 23) begin
            checks++;
            if (pending !== 1'b1 || frame_tick !== 1'b0) begin
                failures++;
                $display("FAIL mid_pend c%0d: pend %b tick %b want 1 0",
                         cyc, pending, frame_tick);
            end
            step();
        end
        checks++;
        if (pending !== 1'b1) begin
            failures++;
            $display("FAIL mid_pend_last: got %b want 1", pending);
        end
        step();
        checks++;
        if (frame_tick !== 1'b1 || pending !== 1'b0) begin
            failures++;
            $display("FAIL mid_tick: tick %b pend %b want 1 0",
                     frame_tick, pending);
        end
        for (int k = 1; k <= 12; k++) begin
            step();
            checks++;
            if (an !== (3'(3'b001 << ((k - 1) / RD)) ^ AINV) ||
                seg !== (e[(k - 1) / RD] ^ SINV) || frame_tick !== 1'b0) begin
                failures++;
                $display("FAIL mid_frame c%0d: an %b seg %h tick %b want seg %h",
                         k, an, seg, frame_tick, e[(k - 1) / RD] ^ SINV);
            end
        end
    endtask

    task automatic test_back_to_back();
        int ticks;
        logic [6:0] e [3];
        e[0] = 7'h4F;
        e[1] = 7'h4F;
        e[2] = 7'h5B;
        ticks = 0;
        run_to(36);
        load = 1'b1;
        cen  = 4'd3;
        dez  = 4'd7;
        und  = 4'd7;
        step();
        load = 1'b0;
        step();
        load = 1'b1;
        cen  = 4'd2;
        dez  = 4'd3;
        und  = 4'd3;
        step();
        load = 1'b0;
        while (cyc < 48) begin
            step();
            if (frame_tick === 1'b1) ticks++;
        end
        for (int k = 1; k <= 12; k++) begin
            step();
            if (frame_tick === 1'b1) ticks++;
            checks++;
            if (seg !== (e[(k - 1) / RD] ^ SINV)) begin
                failures++;
                $display("FAIL b2b_seg c%0d: got %h want %h",
                         k, seg, e[(k - 1) / RD] ^ SINV);
            end
        end
        checks++;
        if (ticks != 1) begin
            failures++;
            $display("FAIL b2b_ticks: got %0d want 1", ticks);
        end
    endtask

    task automatic test_coincident();
        logic [6:0] e [3];
        e[0] = 7'h7F;
        e[1] = ZL;
        e[2] = ZL;
        run_to(71);
        load = 1'b1;
        cen  = 4'd0;
        dez  = 4'd0;
        und  = 4'd8;
        step();
        load = 1'b0;
        checks++;
        if (frame_tick !== 1'b1 || pending !== 1'b0) begin
            failures++;
            $display("FAIL coin_tick: tick %b pend %b want 1 0",
                     frame_tick, pending);
        end
        for (int k = 1; k <= 12; k++) begin
            step();
            checks++;
            if (seg !== (e[(k - 1) / RD] ^ SINV) || pending !== 1'b0) begin
                failures++;
                $display("FAIL coin_frame c%0d: seg %h pend %b want %h 0",
                         k, seg, pending, e[(k - 1) / RD] ^ SINV);
            end
        end
    endtask

    task automatic test_invalid();
        logic [6:0] e [3];
        e[0] = 7'h6D;
        e[1] = 7'h40;
        e[2] = ZL;
        run_to(84);
        load = 1'b1;
        cen  = 4'd0;
        dez  = 4'hC;
        und  = 4'd5;
        step();
        load = 1'b0;
        run_to(96);
        checks++;
        if (frame_tick !== 1'b1) begin
            failures++;
            $display("FAIL inv_tick: got %b want 1", frame_tick);
        end
        for (int k = 1; k <= 12; k++) begin
            step();
            checks++;
            if (seg !== (e[(k - 1) / RD] ^ SINV)) begin
                failures++;
                $display("FAIL inv_seg c%0d: got %h want %h",
                         k, seg, e[(k - 1) / RD] ^ SINV);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [6:0] e [3];
        e[0] = 7'h3F;
        e[1] = ZL;
        e[2] = ZL;
        run_to(108);
        load = 1'b1;
        cen  = 4'd9;
        dez  = 4'd9;
        und  = 4'd9;
        step();
        load = 1'b0;
        checks++;
        if (pending !== 1'b1) begin
            failures++;
            $display("FAIL ar_pend: got %b want 1", pending);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (seg !== SINV || an !== AINV || pending !== 1'b0 ||
            frame_tick !== 1'b0) begin
            failures++;
            $display("FAIL ar_off: seg %h an %b pend %b tick %b",
                     seg, an, pending, frame_tick);
        end
        @(posedge clk);
        #1;
        checks++;
        if (seg !== SINV || an !== AINV) begin
            failures++;
            $display("FAIL ar_hold: seg %h an %b", seg, an);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        for (int k = 1; k <= 16; k++) begin
            step();
            checks++;
            if (an !== (3'(3'b001 << (((k - 1) / RD) % 3)) ^ AINV) ||
                seg !== (e[((k - 1) / RD) % 3] ^ SINV) ||
                frame_tick !== 1'b0 || pending !== 1'b0) begin
                failures++;
                $display("FAIL ar_frame c%0d: an %b seg %h tick %b pend %b",
                         k, an, seg, frame_tick, pending);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_load_mid();
        test_back_to_back();
        test_coincident();
        test_invalid();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_display_mux.md
# bcd_display_mux

Time-multiplexed 3-digit seven-segment driver placed directly downstream of the binary-to-BCD converter in the Fibonacci processor datapath. It captures the centenas/dezenas/unidades BCD nibbles on a load strobe and scans them onto a shared segment bus with one-hot digit enables. New values are applied only at a frame boundary, so a frame never mixes old and new digits.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles each digit stays enabled; legal range ≥1.
- `ACTIVE_LOW`, default 1: 1 inverts both `seg` and `an` at the outputs for common-anode boards.
- `clk`  input  1  system clock; all state on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset; one clock domain, no other clocks.
- `load`  input  1  capture strobe; samples `cen`/`dez`/`und` on any edge where high.
- `cen`  input  4  hundreds BCD digit.
- `dez`  input  4  tens BCD digit.
- `und`  input  4  units BCD digit.
- `seg`  output  7  segments {g,f,e,d,c,b,a}, registered.
- `an`  output  3  digit enables, one-hot; bit0=und, bit1=dez, bit2=cen; registered.
- `frame_tick`  output  1  one-cycle pulse when the display register updates.
- `pending`  output  1  captured value is waiting for the next frame boundary.

## Operation
- State: shadow register (12 b), display register (12 b), `pending` flag, refresh counter `cnt` (0..REFRESH_DIV-1), digit index `idx` (0=und, 1=dez, 2=cen).
- `cnt` increments every cycle; at REFRESH_DIV-1 it wraps to 0 and `idx` advances 0→1→2→0. With REFRESH_DIV=1, `idx` advances every cycle.
- Frame boundary: the edge where `idx` goes 2→0.
- `load`=1: shadow ← {cen,dez,und}, `pending` ← 1. Back-to-back loads overwrite the shadow; only the last one before a boundary is shown.
- At a frame boundary with `pending`=1: display ← shadow, `pending` ← 0, `frame_tick`=1 for that one cycle. With `pending`=0, nothing updates and there is no tick.
- `load` on the same edge as the boundary: the incoming inputs bypass straight into the display register, `pending` ends at 0, and `frame_tick` fires.
- Decode, active-high before polarity: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Any nibble >9 shows a dash (40). Blank=00.
- `an` (active-high before polarity) = 1<<idx. `seg` = decode of the selected display nibble.

## Timing
- `seg`/`an` are registered and reflect `idx` and the display register with 1-cycle latency.
- Load-to-display latency: depends on scan position, at most 3·REFRESH_DIV+1 cycles.
- Reset (async, any time, including mid-frame or with a load pending) clears everything:
  - `cnt`=0, `idx`=0, shadow=0, display=0, `pending`=0, `frame_tick`=0.
  - `an` all off, `seg` all off (both after polarity).
- First edge after reset release: `an` selects und and shows "0".
- Each frame lasts 3·REFRESH_DIV cycles.

## Configuration
- Macro `BCD_LEADING_ZERO_BLANK_EN`.
- Defined: cen is blanked when cen==0; dez is blanked when cen==0 and dez==0; und is never blanked. Invalid nibbles (>9) count as nonzero. `an` still cycles normally during blanked digits.
- Undefined: all three digits are always decoded, so leading zeros show "0".

## Test plan
- Reset, REFRESH_DIV=4, hold: after release, `an` sequences 001,010,100 with 4 cycles each. `seg`=3F on every digit (without macro); `frame_tick` never fires.
- Load 1/4/4 mid-frame: `pending`=1 until the 2→0 edge. Then `frame_tick` pulses once, and the digits show und=66, dez=66, cen=06.
- Two loads, 3/7/7 then 2/3/3, within one frame: only 2/3/3 is displayed; one `frame_tick`.
- Load coincident with the boundary, value 0/0/8: displayed at that boundary and `pending` stays 0. With the macro, cen and dez are blank and und=7F; without it, cen=dez=3F.
- Nibble 4'hC on dez: dez shows 40, and with the macro cen=0 stays blank.
- Assert `rst_n` low mid-frame with a load pending: outputs go off immediately, without waiting for a clock. After release, "000" (or blank/blank/0 with the macro) is shown and the earlier load is lost.
